// File: rtl/arbitro_salida_if.sv
// arbitro_salida_if: FIFO-side, downstream and status signals of the two-to-one output arbiter.
// With ARB_COUNT_EN defined the per-source pop counters cnt0/cnt1 are carried as well.
interface arbitro_salida_if;
  logic       empty0, empty1;
  logic [5:0] data_in0, data_in1;
  logic       pop0, pop1;
  logic       pausa_in;
  logic [5:0] data_out;
  logic       valid_out, active_out, idle_out, error_out;
`ifdef ARB_COUNT_EN
  logic [7:0] cnt0, cnt1;
  modport master(output empty0, empty1, data_in0, data_in1, pausa_in,
                 input pop0, pop1, data_out, valid_out, active_out, idle_out, error_out, cnt0, cnt1);
  modport slave(input empty0, empty1, data_in0, data_in1, pausa_in,
                output pop0, pop1, data_out, valid_out, active_out, idle_out, error_out, cnt0, cnt1);
`else
  modport master(output empty0, empty1, data_in0, data_in1, pausa_in,
                 input pop0, pop1, data_out, valid_out, active_out, idle_out, error_out);
  modport slave(input empty0, empty1, data_in0, data_in1, pausa_in,
                output pop0, pop1, data_out, valid_out, active_out, idle_out, error_out);
`endif
endinterface

// File: rtl/arbitro_salida.sv
// arbitro_salida: round-robin merge of two show-ahead FIFOs into one registered stream.
// Optional ARB_COUNT_EN adds 8-bit wrapping pop counters per source.
module arbitro_salida (
  input logic             clk,
  input logic             reset,
  input logic             init,
  arbitro_salida_if.slave bus
);
  typedef enum logic [1:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE} state_t;
  state_t     state_q, state_d;
  logic [5:0] data_q, data_d;
  logic       valid_q, valid_d, err_q, err_d, last_q, last_d;
  logic       go, pop0, pop1;
  // reset/init drop any pop in the same cycle so no partial transfer leaks out
  assign go   = !reset && !init && !bus.pausa_in && (state_q == S_IDLE || state_q == S_ACTIVE);
  assign pop0 = go && !bus.empty0 && (bus.empty1 || last_q);
  assign pop1 = go && !bus.empty1 && (bus.empty0 || !last_q);
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT:   state_d = S_IDLE;
      S_IDLE:   state_d = (!(bus.empty0 && bus.empty1) && !bus.pausa_in) ? S_ACTIVE : S_IDLE;
      S_ACTIVE: state_d = (bus.empty0 && bus.empty1 && !pop0 && !pop1) ? S_IDLE : S_ACTIVE;
      default:  state_d = S_RESET;
    endcase
    if (init) state_d = S_INIT;
    data_d  = pop0 ? bus.data_in0 : pop1 ? bus.data_in1 : data_q;
    valid_d = pop0 || pop1;
    err_d   = !init && (err_q || (pop0 && bus.data_in0[4]) || (pop1 && !bus.data_in1[4]));
    last_d  = init ? 1'b1 : pop0 ? 1'b0 : pop1 ? 1'b1 : last_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end
`ifdef ARB_COUNT_EN
  logic [7:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  assign cnt0_d = init ? 8'd0 : cnt0_q + 8'(pop0);
  assign cnt1_d = init ? 8'd0 : cnt1_q + 8'(pop1);
  always_ff @(posedge clk) begin
    cnt0_q <= reset ? 8'd0 : cnt0_d;
    cnt1_q <= reset ? 8'd0 : cnt1_d;
  end
  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;
`else
`endif
  assign bus.pop0       = pop0;
  assign bus.pop1       = pop1;
  assign bus.data_out   = data_q;
  assign bus.valid_out  = valid_q;
  assign bus.error_out  = err_q;
  assign bus.idle_out   = state_q == S_IDLE;
  assign bus.active_out = state_q == S_ACTIVE;
endmodule

// File: tb/tb_arbitro_salida.sv
// tb_arbitro_salida: directed checks of arbitro_salida against two queue-modelled show-ahead FIFOs.
module tb_arbitro_salida;
  logic clk = 1'b0, reset = 1'b0, init = 1'b0;
  int nvec = 0, nerr = 0;
  logic [5:0] q0[$], q1[$];
  arbitro_salida_if bus();
  arbitro_salida dut (.clk(clk), .reset(reset), .init(init), .bus(bus));
  always #5 clk = ~clk;
  // status vector: {pop0, pop1, valid_out, idle_out, active_out, error_out}
  logic [5:0] st;
  assign st = {bus.pop0, bus.pop1, bus.valid_out, bus.idle_out, bus.active_out, bus.error_out};

  task automatic drive();
    bus.empty0   = q0.size() == 0;
    bus.empty1   = q1.size() == 0;
    bus.data_in0 = q0.size() ? q0[0] : 6'h00;
    bus.data_in1 = q1.size() ? q1[0] : 6'h00;
    #1;
  endtask

  task automatic tick();
    logic p0, p1;
    #1;
    p0 = bus.pop0;
    p1 = bus.pop1;
    @(posedge clk);
    #1;
    if (p0 && q0.size() > 0) void'(q0.pop_front());
    if (p1 && q1.size() > 0) void'(q1.pop_front());
    drive();
  endtask

  task automatic do_init();
    init = 1'b1; drive(); tick();
    init = 1'b0; drive(); tick();
  endtask

  task automatic test_reset();
    bus.pausa_in = 1'b0;
    reset = 1'b1; drive(); tick();
    nvec++; if (st !== 6'b000000) begin nerr++; $display("FAIL reset_status got %b want 000000", st); end
    nvec++; if (bus.data_out !== 6'h00) begin nerr++; $display("FAIL reset_data got %h want 00", bus.data_out); end
    reset = 1'b0; init = 1'b1; drive(); tick();
    nvec++; if (st !== 6'b000000) begin nerr++; $display("FAIL init_status got %b want 000000", st); end
    init = 1'b0; drive(); tick();
    nvec++; if (st !== 6'b000100) begin nerr++; $display("FAIL idle_status got %b want 000100", st); end
  endtask

  task automatic test_single();
    q0.push_back(6'b011011); q0.push_back(6'b000011); drive();
    nvec++; if (st !== 6'b100100) begin nerr++; $display("FAIL single_pop_a got %b want 100100", st); end
    tick();
    nvec++; if (st !== 6'b101011) begin nerr++; $display("FAIL single_pop_b got %b want 101011", st); end
    nvec++; if (bus.data_out !== 6'b011011) begin nerr++; $display("FAIL single_data_a got %b want 011011", bus.data_out); end
    tick();
    nvec++; if (st !== 6'b001011) begin nerr++; $display("FAIL single_last got %b want 001011", st); end
    nvec++; if (bus.data_out !== 6'b000011) begin nerr++; $display("FAIL single_data_b got %b want 000011", bus.data_out); end
    tick();
    nvec++; if (st !== 6'b000101) begin nerr++; $display("FAIL single_idle got %b want 000101", st); end
    nvec++; if (bus.data_out !== 6'b000011) begin nerr++; $display("FAIL single_hold got %b want 000011", bus.data_out); end
  endtask

  task automatic test_round_robin();
    do_init();
    q0.push_back(6'b011010); q1.push_back(6'b111011); drive();
    nvec++; if (st !== 6'b100100) begin nerr++; $display("FAIL rr_first got %b want 100100", st); end
    tick();
    nvec++; if (st !== 6'b011011) begin nerr++; $display("FAIL rr_second got %b want 011011", st); end
    nvec++; if (bus.data_out !== 6'b011010) begin nerr++; $display("FAIL rr_data_a got %b want 011010", bus.data_out); end
    tick();
    nvec++; if (st !== 6'b001011) begin nerr++; $display("FAIL rr_done got %b want 001011", st); end
    nvec++; if (bus.data_out !== 6'b111011) begin nerr++; $display("FAIL rr_data_b got %b want 111011", bus.data_out); end
    tick();
    nvec++; if (st !== 6'b000101) begin nerr++; $display("FAIL rr_idle got %b want 000101", st); end
  endtask

  task automatic test_stall();
    logic [5:0] exp_st[4]  = '{6'b011010, 6'b101010, 6'b011010, 6'b001010};
    logic [5:0] exp_dat[4] = '{6'h01, 6'h31, 6'h02, 6'h32};
    do_init();
    q0 = '{6'h01, 6'h02}; q1 = '{6'h31, 6'h32};
    bus.pausa_in = 1'b1; drive();
    for (int i = 0; i < 3; i++) begin
      nvec++; if (st !== 6'b000100) begin nerr++; $display("FAIL stall_%0d got %b want 000100", i, st); end
      tick();
    end
    nvec++; if (st !== 6'b000100) begin nerr++; $display("FAIL stall_end got %b want 000100", st); end
    bus.pausa_in = 1'b0; drive();
    nvec++; if (st !== 6'b100100) begin nerr++; $display("FAIL resume got %b want 100100", st); end
    for (int i = 0; i < 4; i++) begin
      tick();
      nvec++; if (st !== exp_st[i]) begin nerr++; $display("FAIL resume_st_%0d got %b want %b", i, st, exp_st[i]); end
      nvec++; if (bus.data_out !== exp_dat[i]) begin nerr++; $display("FAIL resume_dat_%0d got %h want %h", i, bus.data_out, exp_dat[i]); end
    end
    tick();
    nvec++; if (st !== 6'b000100) begin nerr++; $display("FAIL stall_idle got %b want 000100", st); end
  endtask

  task automatic test_error();
    do_init();
    q1.push_back(6'b101101); drive();
    nvec++; if (st !== 6'b010100) begin nerr++; $display("FAIL err_pop got %b want 010100", st); end
    tick();
    nvec++; if (st !== 6'b001011) begin nerr++; $display("FAIL err_set got %b want 001011", st); end
    nvec++; if (bus.data_out !== 6'b101101) begin nerr++; $display("FAIL err_fwd got %b want 101101", bus.data_out); end
    tick(); tick();
    nvec++; if (st !== 6'b000101) begin nerr++; $display("FAIL err_sticky got %b want 000101", st); end
    init = 1'b1; drive(); tick();
    nvec++; if (st !== 6'b000000) begin nerr++; $display("FAIL err_clear got %b want 000000", st); end
    nvec++; if (bus.data_out !== 6'b101101) begin nerr++; $display("FAIL init_hold got %b want 101101", bus.data_out); end
    init = 1'b0; drive(); tick();
    nvec++; if (st !== 6'b000100) begin nerr++; $display("FAIL err_idle got %b want 000100", st); end
  endtask

  task automatic test_reset_mid();
    q0 = '{6'h05, 6'h06, 6'h07}; drive();
    tick();
    nvec++; if (st !== 6'b101010) begin nerr++; $display("FAIL mid_run got %b want 101010", st); end
    reset = 1'b1; drive();
    nvec++; if (st !== 6'b001010) begin nerr++; $display("FAIL mid_drop got %b want 001010", st); end
    tick();
    nvec++; if (st !== 6'b000000) begin nerr++; $display("FAIL mid_reset got %b want 000000", st); end
    nvec++; if (bus.data_out !== 6'h00) begin nerr++; $display("FAIL mid_data got %h want 00", bus.data_out); end
    nvec++; if (q0.size() != 2) begin nerr++; $display("FAIL mid_words got %0d want 2", q0.size()); end
    q0.delete(); q1.delete();
    reset = 1'b0; drive(); tick(); tick();
    nvec++; if (st !== 6'b000100) begin nerr++; $display("FAIL mid_idle got %b want 000100", st); end
  endtask

`ifdef ARB_COUNT_EN
  task automatic test_count();
    do_init();
    for (int i = 0; i < 257; i++) q0.push_back(6'h00);
    drive();
    for (int i = 0; i < 300 && q0.size() > 0; i++) tick();
    nvec++; if (q0.size() != 0) begin nerr++; $display("FAIL cnt_timeout left %0d want 0", q0.size()); end
    nvec++; if (bus.cnt0 !== 8'd1) begin nerr++; $display("FAIL cnt0_wrap got %0d want 1", bus.cnt0); end
    nvec++; if (bus.cnt1 !== 8'd0) begin nerr++; $display("FAIL cnt1_zero got %0d want 0", bus.cnt1); end
    q0 = '{6'h04}; q1 = '{6'h30, 6'h31}; drive();
    tick(); tick();
    nvec++; if ({bus.cnt0, bus.cnt1} !== {8'd2, 8'd1}) begin nerr++; $display("FAIL cnt_mix got %0d/%0d want 2/1", bus.cnt0, bus.cnt1); end
    reset = 1'b1; drive(); tick();
    nvec++; if ({bus.cnt0, bus.cnt1, bus.valid_out} !== 17'd0) begin nerr++; $display("FAIL cnt_reset got %0d/%0d/%b want 0/0/0", bus.cnt0, bus.cnt1, bus.valid_out); end
    q0.delete(); q1.delete();
    reset = 1'b0; drive(); tick(); tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_error();
    test_reset_mid();
`ifdef ARB_COUNT_EN
    test_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/arbitro_salida.md
ARBITRO_SALIDA -- requirements
Module: arbitro_salida

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port init  input  1  level; forces INIT state and clears status.
REQ-004 SHALL have ports empty0, empty1  input  1 each  destination FIFO D0/D1 empty flags.
REQ-005 SHALL have ports data_in0, data_in1  input  6 each  show-ahead head word of D0/D1: [5]=VC, [4]=dest, [3:0]=payload.
REQ-006 SHALL have ports pop0, pop1  output  1 each  combinational pop to D0/D1; consumes the current head word in the same cycle.
REQ-007 SHALL have port pausa_in  input  1  downstream stall; no pop while high.
REQ-008 SHALL have ports data_out  output  6, and valid_out  output  1  registered merged stream.
REQ-009 SHALL have ports active_out, idle_out, error_out  output  1 each  state and sticky error flags.

Function
REQ-010 SHALL implement FSM states RESET, INIT, IDLE, ACTIVE.
REQ-011 RESET: entered on any cycle with reset=1; transitions to INIT on the first cycle with reset=0.
REQ-012 INIT: remains while init=1; transitions to IDLE when init=0; init=1 in any state forces INIT on the next edge.
REQ-013 IDLE: idle_out=1; transitions to ACTIVE when (empty0=0 or empty1=0) and pausa_in=0.
REQ-014 ACTIVE: active_out=1; transitions to IDLE when empty0=1, empty1=1, and no pop is issued that cycle.
REQ-015 Pops SHALL be issued only in IDLE or ACTIVE with pausa_in=0; at most one of pop0/pop1 is high per cycle.
REQ-016 Arbitration SHALL be round-robin: if only one FIFO is non-empty, pop that FIFO; if both are non-empty, pop the FIFO not served last.
REQ-017 The last-served pointer SHALL update only on a pop; its reset/init value is 1, so D0 wins the first tie.
REQ-018 A popped word SHALL appear on data_out with valid_out=1 on the next rising edge (latency 1).
REQ-019 With no pop, valid_out SHALL be 0 next cycle and data_out SHALL hold its last value.
REQ-020 pausa_in=1 SHALL suppress pops combinationally in the same cycle; no word is lost or duplicated.
REQ-021 pop0/pop1 SHALL never be asserted when the corresponding emptyX=1.
REQ-022 A popped word whose bit[4] differs from its source index (D0 expects 0, D1 expects 1) SHALL set error_out=1 from the next edge; the word is still forwarded.
REQ-023 error_out SHALL be sticky until reset or INIT.
REQ-024 reset or init asserted mid-transfer SHALL drop the pop that cycle; no partial word is output.

Reset
REQ-025 With reset=1 at a clock edge, the block SHALL load the following on that edge: state=RESET, data_out=0, valid_out=0, error_out=0, active_out=0, idle_out=0, pointer=1.
REQ-026 pop0 and pop1 SHALL be 0 while in RESET or INIT.
REQ-027 INIT SHALL clear valid_out, error_out and the pointer as reset does; data_out SHALL be held.

Configuration
REQ-028 Macro ARB_COUNT_EN defined SHALL add outputs cnt0 and cnt1, each an 8-bit output counting words popped from D0/D1.
REQ-029 cnt0 and cnt1 SHALL increment on each pop of their FIFO, wrap 255->0, and clear on reset or INIT.
REQ-030 Without ARB_COUNT_EN, the counters and ports SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 reset 1 cycle, init 1 cycle, both FIFOs empty -> state IDLE, idle_out=1, pop0=pop1=0, valid_out=0.
REQ-032 D0 holds 011011, 000011; D1 empty -> pop0 in two consecutive cycles; data_out=011011 then 000011, each valid one cycle later; then IDLE.
REQ-033 D0 holds 011010, D1 holds 111011, both ready together -> pop order D0, D1; data_out 011010 then 111011.
REQ-034 Both FIFOs non-empty, pausa_in=1 for 3 cycles -> no pops and valid_out=0 during the stall; resumes with the correct round-robin winner.
REQ-035 D1 head = 101101 (bit[4]=0) is popped -> word forwarded and error_out=1 next edge; error_out stays 1 until init pulse.
REQ-036 With ARB_COUNT_EN, 257 words popped from D0 -> cnt0=1, cnt1=0; reset mid-stream -> both counters 0 and valid_out=0.
